// File: rtl/gps_ca_codegen.sv
// gps_ca_codegen
// Generates the 1023-chip GPS C/A Gold code for one selectable PRN (1-32).
// Runs entirely on the 10.23 MHz fast clock; an internal divider produces the
// 1.023 MHz chip rate as a clock-enable, so no second clock domain exists.
//
// Parameters:
//   CHIP_DIV     fast-clock cycles per chip (1..1023)
//   CNT_W        divider counter width, 2^CNT_W >= CHIP_DIV
// Ports:
//   gps_clk_fast in   sole clock
//   gps_rst_n    in   asynchronous active-low reset
//   prn_sel      in   PRN number, sampled only on an accepted start (1-32)
//   start        in   single-cycle request to (re)load prn_sel, begin at chip 0
//   stop         in   abort generation, return to IDLE (wins over start)
//   busy         out  high while in RUN
//   prn_err      out  1-cycle pulse after a start with an illegal prn_sel
//   chip_valid   out  1-cycle strobe qualifying ca_chip, chip_idx and epoch
//   ca_chip      out  C/A chip value
//   chip_idx     out  index of the current chip, 0-1022
//   epoch        out  high with chip_valid on chip 1022
//   epoch_cnt    out  completed epochs since the last accepted start (wraps)

module gps_ca_codegen #(
    parameter int CHIP_DIV = 10,
    parameter int CNT_W    = 10
) (
    input  logic       gps_clk_fast,
    input  logic       gps_rst_n,
    input  logic [5:0] prn_sel,
    input  logic       start,
    input  logic       stop,
    output logic       busy,
    output logic       prn_err,
    output logic       chip_valid,
    output logic       ca_chip,
    output logic [9:0] chip_idx,
    output logic       epoch,
    output logic [7:0] epoch_cnt
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CHIP_DIV - 1);
    localparam logic [9:0]       CHIP_LAST = 10'd1022;

    state_t        state_q;
    logic [5:0]    prn_q;
    logic [10:1]   g1_q;
    logic [10:1]   g2_q;
    logic [CNT_W-1:0] div_q;
    logic [9:0]    chipCnt_q;
    logic          prnErr_q;
    logic          chipValid_q;
    logic          caChip_q;
    logic [9:0]    chipIdx_q;
    logic          epoch_q;
    logic [7:0]    epochCnt_q;

    logic          prnLegal;
    logic [3:0]    tapA;
    logic [3:0]    tapB;
    logic          g2Sel;
    logic          g1Fb;
    logic          g2Fb;
    logic [10:1]   g1_d;
    logic [10:1]   g2_d;

    assign prnLegal = (prn_sel != 6'd0) && (prn_sel <= 6'd32);

    // Phase-selector tap pair for the latched PRN. The default is never used
    // because only legal PRNs are ever latched.
    always_comb begin
        tapA = 4'd1;
        tapB = 4'd1;
        case (prn_q)
            6'd1:  begin tapA = 4'd2; tapB = 4'd6;  end
            6'd2:  begin tapA = 4'd3; tapB = 4'd7;  end
            6'd3:  begin tapA = 4'd4; tapB = 4'd8;  end
            6'd4:  begin tapA = 4'd5; tapB = 4'd9;  end
            6'd5:  begin tapA = 4'd1; tapB = 4'd9;  end
            6'd6:  begin tapA = 4'd2; tapB = 4'd10; end
            6'd7:  begin tapA = 4'd1; tapB = 4'd8;  end
            6'd8:  begin tapA = 4'd2; tapB = 4'd9;  end
            6'd9:  begin tapA = 4'd3; tapB = 4'd10; end
            6'd10: begin tapA = 4'd2; tapB = 4'd3;  end
            6'd11: begin tapA = 4'd3; tapB = 4'd4;  end
            6'd12: begin tapA = 4'd5; tapB = 4'd6;  end
            6'd13: begin tapA = 4'd6; tapB = 4'd7;  end
            6'd14: begin tapA = 4'd7; tapB = 4'd8;  end
            6'd15: begin tapA = 4'd8; tapB = 4'd9;  end
            6'd16: begin tapA = 4'd9; tapB = 4'd10; end
            6'd17: begin tapA = 4'd1; tapB = 4'd4;  end
            6'd18: begin tapA = 4'd2; tapB = 4'd5;  end
            6'd19: begin tapA = 4'd3; tapB = 4'd6;  end
            6'd20: begin tapA = 4'd4; tapB = 4'd7;  end
            6'd21: begin tapA = 4'd5; tapB = 4'd8;  end
            6'd22: begin tapA = 4'd6; tapB = 4'd9;  end
            6'd23: begin tapA = 4'd1; tapB = 4'd3;  end
            6'd24: begin tapA = 4'd4; tapB = 4'd6;  end
            6'd25: begin tapA = 4'd5; tapB = 4'd7;  end
            6'd26: begin tapA = 4'd6; tapB = 4'd8;  end
            6'd27: begin tapA = 4'd7; tapB = 4'd9;  end
            6'd28: begin tapA = 4'd8; tapB = 4'd10; end
            6'd29: begin tapA = 4'd1; tapB = 4'd6;  end
            6'd30: begin tapA = 4'd2; tapB = 4'd7;  end
            6'd31: begin tapA = 4'd3; tapB = 4'd8;  end
            6'd32: begin tapA = 4'd4; tapB = 4'd9;  end
            default: begin tapA = 4'd1; tapB = 4'd1; end
        endcase
    end

    // One LFSR step: stage N moves to N+1, feedback enters stage 1.
    assign g2Sel = g2_q[tapA] ^ g2_q[tapB];
    assign g1Fb  = g1_q[3] ^ g1_q[10];
    assign g2Fb  = g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10];
    assign g1_d  = {g1_q[9:1], g1Fb};
    assign g2_d  = {g2_q[9:1], g2Fb};

    // Control FSM, chip-rate divider and registered chip outputs.
    // Stop has priority over start; a legal start from either state restarts
    // the code at chip 0 and suppresses any strobe on that same edge.
    always_ff @(posedge gps_clk_fast or negedge gps_rst_n) begin
        if (!gps_rst_n) begin
            state_q     <= IDLE;
            prn_q       <= 6'd0;
            g1_q        <= '0;
            g2_q        <= '0;
            div_q       <= '0;
            chipCnt_q   <= '0;
            prnErr_q    <= 1'b0;
            chipValid_q <= 1'b0;
            caChip_q    <= 1'b0;
            chipIdx_q   <= '0;
            epoch_q     <= 1'b0;
            epochCnt_q  <= '0;
        end else begin
            prnErr_q    <= 1'b0;
            chipValid_q <= 1'b0;
            epoch_q     <= 1'b0;
            if (stop) begin
                state_q  <= IDLE;
                caChip_q <= 1'b0;
            end else if (start && prnLegal) begin
                state_q    <= RUN;
                prn_q      <= prn_sel;
                g1_q       <= '1;
                g2_q       <= '1;
                div_q      <= '0;
                chipCnt_q  <= '0;
                epochCnt_q <= '0;
            end else begin
                prnErr_q <= start;
                if (state_q == RUN) begin
                    if (div_q == DIV_LAST) begin
                        div_q       <= '0;
                        caChip_q    <= g1_q[10] ^ g2Sel;
                        chipIdx_q   <= chipCnt_q;
                        chipValid_q <= 1'b1;
                        epoch_q     <= (chipCnt_q == CHIP_LAST);
                        g1_q        <= g1_d;
                        g2_q        <= g2_d;
                        if (chipCnt_q == CHIP_LAST) begin
                            chipCnt_q  <= '0;
                            epochCnt_q <= epochCnt_q + 8'd1;
                        end else begin
                            chipCnt_q <= chipCnt_q + 10'd1;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
            end
        end
    end

    assign busy       = (state_q == RUN);
    assign prn_err    = prnErr_q;
    assign chip_valid = chipValid_q;
    assign ca_chip    = caChip_q;
    assign chip_idx   = chipIdx_q;
    assign epoch      = epoch_q;
    assign epoch_cnt  = epochCnt_q;

endmodule

// File: tb/tb_gps_ca_codegen.sv
// tb_gps_ca_codegen
// Directed testbench for gps_ca_codegen. One instance runs at the nominal
// 10 fast clocks per chip; a second with one clock per chip sweeps all 32 PRNs
// against a behavioural Gold-code model. Inputs change and outputs are sampled
// on the falling clock edge.

module tb_gps_ca_codegen;

    logic       clk = 1'b0;
    logic       rstN;

    // Nominal-rate instance signals
    logic       start, stop;
    logic [5:0] prnSel;
    logic       busy, prnErr, chipValid, caChip, epoch;
    logic [9:0] chipIdx;
    logic [7:0] epochCnt;

    // One-chip-per-clock instance signals
    logic       fStart, fStop;
    logic [5:0] fPrnSel;
    logic       fBusy, fPrnErr, fChipValid, fCaChip, fEpoch;
    logic [9:0] fChipIdx;
    logic [7:0] fEpochCnt;

    int checkCount = 0;
    int passCount  = 0;

    bit gold [0:1022];
    int tapA [1:32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tapB [1:32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    always #5 clk = ~clk;

    gps_ca_codegen #(.CHIP_DIV(10), .CNT_W(10)) dut (
        .gps_clk_fast(clk),      .gps_rst_n(rstN),
        .prn_sel(prnSel),        .start(start),        .stop(stop),
        .busy(busy),             .prn_err(prnErr),     .chip_valid(chipValid),
        .ca_chip(caChip),        .chip_idx(chipIdx),   .epoch(epoch),
        .epoch_cnt(epochCnt)
    );

    gps_ca_codegen #(.CHIP_DIV(1), .CNT_W(1)) dutFast (
        .gps_clk_fast(clk),      .gps_rst_n(rstN),
        .prn_sel(fPrnSel),       .start(fStart),       .stop(fStop),
        .busy(fBusy),            .prn_err(fPrnErr),    .chip_valid(fChipValid),
        .ca_chip(fCaChip),       .chip_idx(fChipIdx),  .epoch(fEpoch),
        .epoch_cnt(fEpochCnt)
    );

    // Single comparison point: counts every check, reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Drive one cycle of start/stop on the nominal instance, then release them.
    task automatic applyStimulus(input logic st, input logic sp, input logic [5:0] prn);
        start  = st;
        stop   = sp;
        prnSel = prn;
        tick();
        start  = 1'b0;
        stop   = 1'b0;
    endtask

    // Cycles until the next chip strobe; returns 41 if none arrives in time.
    task automatic nextStrobe(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!chipValid && cycles <= 40);
    endtask

    // Count cycles over a window in which the nominal instance shows activity.
    task automatic activeCycles(input int n, output int cnt);
        cnt = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            if (chipValid || busy) cnt++;
        end
    endtask

    function automatic logic [31:0] allOuts();
        return 32'({busy, prnErr, chipValid, caChip, epoch, chipIdx, epochCnt});
    endfunction

    function automatic logic [31:0] allFastOuts();
        return 32'({fBusy, fPrnErr, fChipValid, fCaChip, fEpoch, fChipIdx, fEpochCnt});
    endfunction

    // Behavioural Gold-code reference: stage 1 is the leftmost bit here.
    task automatic buildGold(input int prn);
        logic [1:10] g1, g2;
        logic fb1, fb2;
        g1 = '1;
        g2 = '1;
        for (int i = 0; i < 1023; i++) begin
            gold[i] = g1[10] ^ g2[tapA[prn]] ^ g2[tapB[prn]];
            fb1 = g1[3] ^ g1[10];
            fb2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            g1  = {fb1, g1[1:9]};
            g2  = {fb2, g2[1:9]};
        end
    endtask

    initial begin
        int cyc, cnt, guard, sinceEpoch;
        int idxErr, chipErr, epErr, spErr, err;
        logic [9:0] pat;
        logic [3:0] pat4;

        rstN = 1'b0; start = 1'b0; stop = 1'b0; prnSel = 6'd0;
        fStart = 1'b0; fStop = 1'b0; fPrnSel = 6'd0;
        tick(); tick();
        checkOutput("resetOuts", allOuts(), 32'd0);
        checkOutput("resetFastOuts", allFastOuts(), 32'd0);
        rstN = 1'b1;
        tick();

        // PRN 1: latency, strobe spacing and first ten chips
        applyStimulus(1'b1, 1'b0, 6'd1);
        checkOutput("busyAfterStart", 32'(busy), 32'd1);
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            nextStrobe(cyc);
            checkOutput($sformatf("prn1Spacing%0d", k), cyc, 32'd10);
            if (k == 0) checkOutput("prn1FirstIdx", 32'(chipIdx), 32'd0);
            pat = {pat[8:0], caChip};
        end
        checkOutput("prn1First10", 32'(pat), 32'b1100100000);

        // PRN 2 via restart while running
        applyStimulus(1'b1, 1'b0, 6'd2);
        pat = '0;
        for (int k = 0; k < 10; k++) begin
            nextStrobe(cyc);
            if (k == 0) checkOutput("prn2RestartLatency", cyc, 32'd10);
            pat = {pat[8:0], caChip};
        end
        checkOutput("prn2First10", 32'(pat), 32'b1110010000);

        // PRN 1 over two full epochs
        buildGold(1);
        applyStimulus(1'b1, 1'b0, 6'd1);
        idxErr = 0; chipErr = 0; epErr = 0; spErr = 0; sinceEpoch = 0;
        for (int i = 0; i < 2046; i++) begin
            nextStrobe(cyc);
            if (cyc != 10) spErr++;
            if (int'(chipIdx) != i % 1023) idxErr++;
            if (caChip != gold[i % 1023]) chipErr++;
            if (epoch != (i % 1023 == 1022)) epErr++;
            if (i == 0) checkOutput("epochCntStart", 32'(epochCnt), 32'd0);
            if (i == 1022) begin
                checkOutput("epochCnt1", 32'(epochCnt), 32'd1);
                sinceEpoch = 0;
            end else begin
                sinceEpoch += cyc;
            end
            if (i == 2045) begin
                checkOutput("epochCnt2", 32'(epochCnt), 32'd2);
                checkOutput("epochSpacing", sinceEpoch, 32'd10230);
            end
        end
        checkOutput("fullSpacingErrs", spErr, 32'd0);
        checkOutput("fullIdxErrs", idxErr, 32'd0);
        checkOutput("fullChipErrs", chipErr, 32'd0);
        checkOutput("fullEpochErrs", epErr, 32'd0);

        // Stop after chip 499 has been issued
        applyStimulus(1'b1, 1'b0, 6'd1);
        guard = 0;
        do begin
            nextStrobe(cyc);
            guard++;
        end while (chipIdx != 10'd499 && guard < 600);
        applyStimulus(1'b0, 1'b1, 6'd0);
        checkOutput("stopBusy", 32'(busy), 32'd0);
        checkOutput("stopCleared", 32'({chipValid, caChip, epoch}), 32'd0);
        checkOutput("stopIdxHold", 32'(chipIdx), 32'd499);
        activeCycles(25, cnt);
        checkOutput("stopQuiet", cnt, 32'd0);

        // Start and stop together: stop wins, no error pulse even if illegal
        applyStimulus(1'b1, 1'b1, 6'd3);
        checkOutput("startStopBusy", 32'(busy), 32'd0);
        checkOutput("startStopNoErr", 32'(prnErr), 32'd0);
        applyStimulus(1'b1, 1'b1, 6'd0);
        checkOutput("startStopIllegalNoErr", 32'(prnErr), 32'd0);
        activeCycles(25, cnt);
        checkOutput("startStopQuiet", cnt, 32'd0);

        // Illegal PRN numbers
        applyStimulus(1'b1, 1'b0, 6'd0);
        checkOutput("prn0Err", 32'(prnErr), 32'd1);
        tick();
        checkOutput("prn0ErrOneCycle", 32'(prnErr), 32'd0);
        applyStimulus(1'b1, 1'b0, 6'd33);
        checkOutput("prn33Err", 32'(prnErr), 32'd1);
        tick();
        checkOutput("prn33ErrOneCycle", 32'(prnErr), 32'd0);
        activeCycles(25, cnt);
        checkOutput("illegalQuiet", cnt, 32'd0);

        // Restart with PRN 5 once chip 300 has been issued
        applyStimulus(1'b1, 1'b0, 6'd1);
        guard = 0;
        do begin
            nextStrobe(cyc);
            guard++;
        end while (chipIdx != 10'd300 && guard < 400);
        applyStimulus(1'b1, 1'b0, 6'd5);
        pat4 = '0;
        for (int k = 0; k < 4; k++) begin
            nextStrobe(cyc);
            if (k == 0) begin
                checkOutput("prn5RestartLatency", cyc, 32'd10);
                checkOutput("prn5FirstIdx", 32'(chipIdx), 32'd0);
            end
            pat4 = {pat4[2:0], caChip};
        end
        checkOutput("prn5First4", 32'(pat4), 32'b1001);

        // Asynchronous reset in the middle of a cycle while a strobe is visible
        nextStrobe(cyc);
        #2 rstN = 1'b0;
        #1 checkOutput("asyncResetOuts", allOuts(), 32'd0);
        tick(); tick();
        rstN = 1'b1;
        activeCycles(30, cnt);
        checkOutput("postResetQuiet", cnt, 32'd0);

        // All 32 PRNs at one chip per clock against the reference model
        for (int p = 1; p <= 32; p++) begin
            buildGold(p);
            fStart  = 1'b1;
            fPrnSel = 6'(p);
            tick();
            fStart  = 1'b0;
            err = 0;
            for (int i = 0; i < 1023; i++) begin
                tick();
                if (!fChipValid || fCaChip != gold[i] || int'(fChipIdx) != i
                    || fEpoch != (i == 1022)) err++;
            end
            checkOutput($sformatf("prn%0dSequence", p), err, 32'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/gps_ca_codegen.md
# gps_ca_codegen

- Generates the 1023-chip GPS C/A Gold code for one selectable PRN (1-32).
- Sits directly downstream of the GPS clock generator and runs on its fast (10.23 MHz) clock.
- An internal divider produces the 1.023 MHz chip rate as a clock-enable strobe, so no second clock domain is needed.
- Output is a registered chip stream with per-chip valid, chip index and code-epoch markers for the correlator/modulator stage.

## Interface

Parameters:
- CHIP_DIV, 10, fast-clock cycles per chip; legal range 1 to 1023.
- CNT_W, 10, width of the internal divider counter; must satisfy 2^CNT_W >= CHIP_DIV.

Ports:
- gps_clk_fast  input  1  sole clock; 10.23 MHz from the clock generator.
- gps_rst_n  input  1  reset; asynchronous assert, active-low.
- prn_sel  input  6  PRN number, sampled only on an accepted start; legal values 1-32.
- start  input  1  single-cycle request to (re)load prn_sel and begin from chip 0.
- stop  input  1  abort generation; return to IDLE.
- busy  output  1  high while in RUN.
- prn_err  output  1  1-cycle pulse when a start carries an illegal prn_sel.
- chip_valid  output  1  1-cycle strobe; ca_chip, chip_idx and epoch are valid in this cycle.
- ca_chip  output  1  C/A chip value (1 = logic one).
- chip_idx  output  10  index of the current chip, 0-1022.
- epoch  output  1  high with chip_valid on chip 1022 (last chip of the 1 ms period).
- epoch_cnt  output  8  count of completed epochs since the last accepted start; wraps 255 -> 0.

## Operation

- Two states, IDLE and RUN.
- Reset value of all outputs is 0. Reset state is IDLE. All registers in this block reset.
- G1 LFSR, 10 bits, stages 1..10:
  - feedback = s3 ^ s10
  - shift moves sN -> sN+1; feedback enters s1
  - output = s10
- G2 LFSR, 10 bits:
  - feedback = s2^s3^s6^s8^s9^s10
  - same shift direction as G1
  - phase-selector output = XOR of two taps chosen by PRN
- Tap pairs by PRN:
  - 1:(2,6) 2:(3,7) 3:(4,8) 4:(5,9) 5:(1,9) 6:(2,10) 7:(1,8) 8:(2,9)
  - 9:(3,10) 10:(2,3) 11:(3,4) 12:(5,6) 13:(6,7) 14:(7,8) 15:(8,9) 16:(9,10)
  - 17:(1,4) 18:(2,5) 19:(3,6) 20:(4,7) 21:(5,8) 22:(6,9) 23:(1,3) 24:(4,6)
  - 25:(5,7) 26:(6,8) 27:(7,9) 28:(8,10) 29:(1,6) 30:(2,7) 31:(3,8) 32:(4,9)
- Chip = G1.s10 XOR G2 phase-selector output.
- Accepted start (stop low, prn_sel in 1..32), valid from either IDLE or RUN:
  - latch PRN
  - load G1 and G2 to all ones
  - divider = 0, chip counter = 0, epoch_cnt = 0
  - state = RUN
  - a start while in RUN restarts generation.
- Illegal start (prn_sel 0 or >32):
  - pulse prn_err
  - no change to state, LFSRs, latched PRN or counters.
- RUN behaviour:
  - the divider counts 0..CHIP_DIV-1, then wraps.
  - On the edge where divider == CHIP_DIV-1:
    - register ca_chip from the current LFSR contents
    - chip_idx <= chip counter
    - chip_valid <= 1
    - epoch <= (chip counter == 1022)
    - advance both LFSRs one step
    - chip counter increments, wrapping 1022 -> 0
    - epoch_cnt increments when chip counter == 1022.
  - chip_valid and epoch are 0 on every other edge.
- Stop high in any state:
  - next edge state = IDLE
  - chip_valid, epoch and ca_chip clear to 0
  - chip_idx and epoch_cnt hold.
  - Stop and start in the same cycle: stop wins, start is ignored, no prn_err.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0, no partial chip strobe.

## Timing

- Accepted start at edge E0 -> busy high after E0.
- First chip_valid (chip_idx 0) is high in the cycle after edge E0+CHIP_DIV, then exactly every CHIP_DIV cycles.
- CHIP_DIV = 1: chip_valid is continuously high in RUN; one chip per cycle.
- Chip counter and both LFSRs have period 1023. After chip 1022 both LFSRs equal all ones again.
- Epoch spacing: 1023*CHIP_DIV cycles (1 ms at 10.23 MHz).
- prn_err is registered: high in the cycle after the offending start.
- Restart while running: the new sequence's chip_idx 0 strobe appears CHIP_DIV cycles after the restart edge. No stale strobe is issued between the restart edge and that strobe.

## Test plan

- Reset, PRN 1, CHIP_DIV 10, start:
  - first 10 chips = 1,1,0,0,1,0,0,0,0,0 (octal 1440)
  - first chip_valid 10 cycles after the start edge; strobes spaced 10 cycles.
- PRN 2 -> first 10 chips 1,1,1,0,0,1,0,0,0,0 (octal 1620).
- PRN 1, full sequence:
  - epoch pulses with chip_idx 1022 exactly 10230 cycles apart
  - epoch_cnt 0->1->2
  - the chip stream repeats identically
  - compare all 32 PRNs against a golden Gold-code model over 1023 chips.
- start with prn_sel 0, then with 33:
  - prn_err pulses one cycle each time
  - busy stays 0, no chip_valid.
- Mid-run events:
  - stop at chip 500 -> busy 0 next cycle, outputs cleared, chip_idx holds 499
  - start+stop together -> stays IDLE
  - restart with PRN 5 at chip 300 -> next strobe is chip_idx 0 of PRN 5 (first chips 1,0,0,1,...).
- gps_rst_n asserted asynchronously mid-cycle during RUN:
  - all outputs 0 immediately, with no clock edge needed
  - after release, no strobes until a new start.
